// File: rtl/comet_ii_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : comet_ii_mem_arbiter
//  Description : Shares the single COMET II memory port between the
//                instruction fetcher (IF) and the execute/operand unit (DX).
//                Grants one requester at a time, sequences the memory
//                handshake with wait states, and returns read data with a
//                one-cycle ack pulse to the owner. DX normally wins a tie,
//                but IF is forced after STARVE_MAX consecutive DX grants
//                taken while IF was waiting.
//  Options     : COMET_MEM_TIMEOUT_EN - abort a transfer after TIMEOUT BUSY
//                cycles without mem_ack (rdata = all ones, bus_err pulses).
//  Revision    : 1.0 - initial release
// ============================================================================
module comet_ii_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic          mclk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          dx_req,
    input  logic          dx_we,
    input  logic [AW-1:0] dx_addr,
    input  logic [DW-1:0] dx_wdata,
    output logic          dx_ack,
    output logic [DW-1:0] rdata,
    output logic          bus_err,
    output logic [1:0]    gnt_owner,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DX   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    owner;
    logic [SW-1:0] starve;
    logic          grant_if;
    logic          grant_dx;
    logic          timeout_hit;
    logic          starve_full;

    // Reject parameter values the arbitration and timeout logic cannot honour
    generate
        if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("comet_ii_mem_arbiter: STARVE_MAX and TIMEOUT must be >= 1");
        end
    endgenerate

    assign starve_full = (starve == SW'(STARVE_MAX));

    // State register
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision; DX wins ties unless IF has waited too long
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dx  = 1'b0;
        case (state)
            IDLE: begin
                if (dx_req && !(if_req && starve_full)) begin
                    grant_dx = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_if || grant_dx) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant-time latching of the memory request, read capture and starvation count
    always_ff @(posedge mclk) begin
        if (rst) begin
            owner     <= OWN_NONE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            starve    <= '0;
        end else begin
            if (grant_if) begin
                owner    <= OWN_IF;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                starve   <= '0;
            end else if (grant_dx) begin
                owner     <= OWN_DX;
                mem_we    <= dx_we;
                mem_addr  <= dx_addr;
                mem_wdata <= dx_wdata;
                // Only DX grants that overtake a waiting IF count toward forcing IF
                if (if_req && !starve_full) begin
                    starve <= starve + 1'b1;
                end
            end
            if (state == BUSY) begin
                // A real completion beats a timeout landing in the same cycle
                if (mem_ack) begin
                    if (!mem_we) begin
                        rdata <= mem_rdata;
                    end
                end else if (timeout_hit) begin
                    rdata <= '1;
                end
            end
            if (state == DONE) begin
                owner <= OWN_NONE;
            end
        end
    end

`ifdef COMET_MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] timer;
    logic          err;

    assign timeout_hit = (state == BUSY) && !mem_ack && (timer == TW'(TIMEOUT - 1));

    // BUSY cycle counter, held at zero outside BUSY so it restarts on every entry
    always_ff @(posedge mclk) begin
        if (rst) begin
            timer <= '0;
        end else if (state != BUSY) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Remember whether the transfer now completing was aborted
    always_ff @(posedge mclk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == BUSY) begin
            err <= timeout_hit;
        end
    end

    assign bus_err = (state == DONE) && err;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    assign mem_req   = (state == BUSY);
    assign if_ack    = (state == DONE) && (owner == OWN_IF);
    assign dx_ack    = (state == DONE) && (owner == OWN_DX);
    assign gnt_owner = owner;

endmodule
`default_nettype wire

// File: tb/tb_comet_ii_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comet_ii_mem_arbiter
//  Description : Directed self-checking bench for comet_ii_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comet_ii_mem_arbiter;

    logic        mclk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic        dx_req;
    logic        dx_we;
    logic [15:0] dx_addr;
    logic [15:0] dx_wdata;
    logic        dx_ack;
    logic [15:0] rdata;
    logic        bus_err;
    logic [1:0]  gnt_owner;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles;

    logic [1:0] exp_own [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

    comet_ii_mem_arbiter #(
        .AW         (16),
        .DW         (16),
        .STARVE_MAX (2),
        .TIMEOUT    (8)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .dx_req    (dx_req),
        .dx_we     (dx_we),
        .dx_addr   (dx_addr),
        .dx_wdata  (dx_wdata),
        .dx_ack    (dx_ack),
        .rdata     (rdata),
        .bus_err   (bus_err),
        .gnt_owner (gnt_owner),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dx_req    = 1'b0;
        dx_we     = 1'b0;
        dx_addr   = '0;
        dx_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        check("rst_if_ack",    if_ack,    0);
        check("rst_dx_ack",    dx_ack,    0);
        check("rst_bus_err",   bus_err,   0);
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata",     rdata,     0);
        check("rst_gnt",       gnt_owner, 0);
        rst = 1'b0;
        tick();

        // IF read with ack in the third mem_req cycle
        if_req    = 1'b1;
        if_addr   = 16'h0040;
        mem_rdata = 16'h1234;
        tick();
        check("t1_req_c1",  mem_req,   1);
        check("t1_addr",    mem_addr,  16'h0040);
        check("t1_we",      mem_we,    0);
        check("t1_gnt",     gnt_owner, 2'b01);
        tick();
        check("t1_req_c2",  mem_req,   1);
        tick();
        check("t1_req_c3",  mem_req,   1);
        check("t1_noack",   if_ack,    0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_req_off", mem_req,   0);
        check("t1_if_ack",  if_ack,    1);
        check("t1_dx_ack",  dx_ack,    0);
        check("t1_rdata",   rdata,     16'h1234);
        check("t1_gnt_done", gnt_owner, 2'b01);
        if_req = 1'b0;
        tick();
        check("t1_ack_pulse", if_ack,  0);
        check("t1_gnt_idle",  gnt_owner, 2'b00);

        // DX write, zero-wait memory
        dx_req   = 1'b1;
        dx_we    = 1'b1;
        dx_addr  = 16'h0100;
        dx_wdata = 16'hBEEF;
        tick();
        check("t2_req",   mem_req,   1);
        check("t2_we",    mem_we,    1);
        check("t2_addr",  mem_addr,  16'h0100);
        check("t2_wdata", mem_wdata, 16'hBEEF);
        check("t2_gnt",   gnt_owner, 2'b10);
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        dx_req  = 1'b0;
        dx_we   = 1'b0;
        check("t2_dx_ack", dx_ack, 1);
        check("t2_if_ack", if_ack, 0);
        check("t2_rdata",  rdata,  16'h1234);
        tick();
        check("t2_ack_pulse", dx_ack, 0);

        // Both requesting continuously: DX,DX,IF,DX,DX,IF
        if_req  = 1'b1;
        if_addr = 16'h0300;
        dx_req  = 1'b1;
        dx_we   = 1'b0;
        dx_addr = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            tick();
            check("t3_gnt",  gnt_owner, exp_own[g]);
            check("t3_addr", mem_addr,  (exp_own[g] == 2'b01) ? 16'h0300 : 16'h0200);
            mem_ack   = 1'b1;
            mem_rdata = 16'h1000 + 16'(g);
            tick();
            mem_ack = 1'b0;
            check("t3_if_ack", if_ack, exp_own[g] == 2'b01);
            check("t3_dx_ack", dx_ack, exp_own[g] == 2'b10);
            check("t3_rdata",  rdata,  16'h1000 + 16'(g));
            tick();
            check("t3_gnt_idle", gnt_owner, 2'b00);
        end
        if_req = 1'b0;
        dx_req = 1'b0;
        tick();
        check("t3_quiet", mem_req, 0);

        // Reset during BUSY of a DX read; late mem_ack ignored
        dx_req  = 1'b1;
        dx_we   = 1'b0;
        dx_addr = 16'h0400;
        tick();
        check("t4_busy", mem_req, 1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        dx_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        check("t4_req",   mem_req,   0);
        check("t4_dxack", dx_ack,    0);
        check("t4_rdata", rdata,     0);
        check("t4_gnt",   gnt_owner, 2'b00);
        tick();
        mem_ack = 1'b0;
        check("t4_late_ack",   dx_ack,  0);
        check("t4_late_rdata", rdata,   0);
        check("t4_late_req",   mem_req, 0);

        // Spurious mem_ack while IDLE
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        check("t6_if_ack", if_ack, 0);
        check("t6_dx_ack", dx_ack, 0);
        check("t6_rdata",  rdata,  0);
        tick();
        mem_ack = 1'b0;
        check("t6_rdata2", rdata,   0);
        check("t6_req",    mem_req, 0);

        // IF read with a memory that never answers
        if_req  = 1'b1;
        if_addr = 16'h0050;
        tick();
        req_cycles = 0;
        while (mem_req && req_cycles < 110) begin
            req_cycles++;
            tick();
        end
`ifdef COMET_MEM_TIMEOUT_EN
        check("t5_req_cycles", req_cycles, 8);
        check("t5_if_ack",     if_ack,     1);
        check("t5_bus_err",    bus_err,    1);
        check("t5_rdata",      rdata,      16'hFFFF);
        if_req = 1'b0;
        tick();
        check("t5_ack_pulse", if_ack,  0);
        check("t5_err_pulse", bus_err, 0);
`else
        check("t5_req_cycles", req_cycles, 110);
        check("t5_req_held",   mem_req,    1);
        check("t5_no_ack",     if_ack,     0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        check("t5_if_ack",  if_ack,  1);
        check("t5_bus_err", bus_err, 0);
        check("t5_rdata",   rdata,   16'h7777);
        tick();
`endif
        check("t5_idle_gnt", gnt_owner, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
